out_bcd_converter: RTL and testbench

OUT_BCD_CONVERTER -- requirements
Module: out_bcd_converter

---
 rtl/out_bcd_converter_if.sv | 29 ++
 rtl/out_bcd_converter.sv | 157 +++++++++++++++
 tb/tb_out_bcd_converter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/out_bcd_converter_if.sv
//------------------------------------------------------------------------------
// Module      : out_bcd_converter_if
// Description : Bundle between the CPU output port and the BCD converter.
//               The optional 7-segment bus exists only when OUT_SSEG_EN is
//               defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface out_bcd_converter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
);
  logic [DATA_WIDTH-1:0] in;
  logic [4*DIGITS-1:0]   bcd;
  logic                  valid;
  logic                  busy;
`ifdef OUT_SSEG_EN
  logic [7*DIGITS-1:0]   sseg;

  modport master (output in, input bcd, input valid, input busy, input sseg);
  modport slave  (input in, output bcd, output valid, output busy, output sseg);
`else
  modport master (output in, input bcd, input valid, input busy);
  modport slave  (input in, output bcd, output valid, output busy);
`endif
endinterface

`default_nettype wire

// File: rtl/out_bcd_converter.sv
//------------------------------------------------------------------------------
// Module      : out_bcd_converter
// Description : Watches the CPU output port and, whenever the value changes,
//               converts it to packed BCD with a serial double-dabble
//               (one bit per clock). Result is registered with a one-cycle
//               valid pulse. Optional macro OUT_SSEG_EN adds a registered
//               active-low 7-segment output with leading-zero blanking.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module out_bcd_converter #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  out_bcd_converter_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_last_value;
  logic [DATA_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]      r_scratch;
  logic [BCD_W-1:0]      w_adj;
  logic [BCD_W-1:0]      r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_valid;
  logic                  w_start;
  logic                  w_last_shift;

  // A new conversion starts only when the port value differs from the last capture.
  assign w_start      = (bus.in != r_last_value);
  assign w_last_shift = (r_cnt == CNT_W'(DATA_WIDTH - 1));

  // Double-dabble correction: any nibble >= 5 gets +3 before it is doubled.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                              (r_scratch[4*gi +: 4] + 4'd3) :
                              r_scratch[4*gi +: 4];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = SHIFT;
      SHIFT:   if (w_last_shift) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture, shift/adjust, and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_value <= '0;
      r_bin        <= '0;
      r_scratch    <= '0;
      r_cnt        <= '0;
      r_bcd        <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_last_value <= bus.in;
            r_bin        <= bus.in;
            r_scratch    <= '0;
            r_cnt        <= '0;
          end
        end
        SHIFT: begin
          // Top nibbles that fall off the end give the value modulo 10^DIGITS.
          {r_scratch, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt              <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_bcd   <= r_scratch;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd   = r_bcd;
  assign bus.valid = r_valid;
  assign bus.busy  = (r_state != IDLE);

`ifdef OUT_SSEG_EN
  logic [7*DIGITS-1:0] r_sseg;
  logic [7*DIGITS-1:0] w_sseg;

  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    case (d)
      4'd0:    f_seg7 = 7'b1000000;
      4'd1:    f_seg7 = 7'b1111001;
      4'd2:    f_seg7 = 7'b0100100;
      4'd3:    f_seg7 = 7'b0110000;
      4'd4:    f_seg7 = 7'b0011001;
      4'd5:    f_seg7 = 7'b0010010;
      4'd6:    f_seg7 = 7'b0000010;
      4'd7:    f_seg7 = 7'b1111000;
      4'd8:    f_seg7 = 7'b0000000;
      4'd9:    f_seg7 = 7'b0010000;
      default: f_seg7 = 7'b1111111;
    endcase
  endfunction

  // Segment decode of the finished scratch value, blanking zeros above the top nonzero digit.
  always_comb begin : p_sseg_decode
    logic w_lit;
    w_sseg = '1;
    w_lit  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((r_scratch[4*i +: 4] != 4'd0) || (i == 0)) w_lit = 1'b1;
      w_sseg[7*i +: 7] = w_lit ? f_seg7(r_scratch[4*i +: 4]) : 7'b1111111;
    end
  end

  // Segment register loads alongside bcd; reset shows a single "0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sseg      <= '1;
      r_sseg[6:0] <= 7'b1000000;
    end else if (r_state == DONE) begin
      r_sseg <= w_sseg;
    end
  end

  assign bus.sseg = r_sseg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_out_bcd_converter.sv
//------------------------------------------------------------------------------
// Module      : tb_out_bcd_converter
// Description : Self-checking bench for out_bcd_converter (5-digit and a
//               truncating 3-digit instance). Honours OUT_SSEG_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_out_bcd_converter;

  localparam int DW  = 16;
  localparam int DG  = 5;
  localparam int DG3 = 3;
  localparam int LAT = DW + 2;   // negedges from drive to the negedge showing valid

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  out_bcd_converter_if #(.DATA_WIDTH(DW), .DIGITS(DG))  bus ();
  out_bcd_converter_if #(.DATA_WIDTH(DW), .DIGITS(DG3)) bus3 ();
  assign bus3.in = bus.in;

  out_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(DG))  u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  out_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(DG3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int vectors     = 0;
  int miscompares = 0;
  int busy_cnt    = 0;
  int pulse_cnt   = 0;
  int last_in     = 0;

  // Count busy cycles and valid pulses, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.busy === 1'b1)  busy_cnt++;
    if (bus.valid === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits of v, modulo 10^digits, packed 4 bits per digit.
  function automatic logic [63:0] ref_bcd(input int unsigned v, input int digits);
    logic [63:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      r = r | (64'((v / p) % 10) << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

`ifdef OUT_SSEG_EN
  function automatic logic [6:0] seg_tab(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic logic [63:0] ref_sseg(input int unsigned v);
    logic [63:0] r;
    int unsigned m, p;
    r = '0;
    m = v % 100000;
    p = 1;
    for (int i = 0; i < DG; i++) begin
      if (i > 0 && m < p) r = r | (64'(7'h7F) << (7 * i));
      else                r = r | (64'(seg_tab(int'((m / p) % 10))) << (7 * i));
      p = p * 10;
    end
    return r;
  endfunction
`endif

  // Wait (bounded) for the negedge at which valid is seen; k counts negedges waited.
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.valid !== 1'b1 && k < 60);
  endtask

  task automatic check_result(input int unsigned v, input string tag);
    check({tag, ".bcd"},  64'(bus.bcd),  ref_bcd(v, DG));
    check({tag, ".bcd3"}, 64'(bus3.bcd), ref_bcd(v, DG3));
`ifdef OUT_SSEG_EN
    check({tag, ".sseg"}, 64'(bus.sseg), ref_sseg(v));
`endif
  endtask

  // One full conversion from idle with latency, busy-length and pulse-count checks.
  task automatic conv(input int unsigned v, input string tag);
    int k, b0, p0;
    b0 = busy_cnt;
    p0 = pulse_cnt;
    @(negedge clk);
    bus.in = DW'(v);
    wait_valid(k);
    check({tag, ".lat"}, 64'(k), 64'(LAT));
    check_result(v, tag);
    @(negedge clk);
    check({tag, ".vlow"},  64'(bus.valid), 64'(0));
    check({tag, ".busy"},  64'(busy_cnt - b0), 64'(DW + 1));
    check({tag, ".pulse"}, 64'(pulse_cnt - p0), 64'(1));
    last_in = int'(v);
  endtask

  initial begin
    int k, p0, b0;
    int unsigned v;
    logic [63:0] bcd_hold;
    bus.in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.bcd",   64'(bus.bcd),   64'(0));
    check("rst.valid", 64'(bus.valid), 64'(0));
    check("rst.busy",  64'(bus.busy),  64'(0));
`ifdef OUT_SSEG_EN
    check("rst.sseg",  64'(bus.sseg),  ref_sseg(0));
`endif
    rst_n = 1'b1;

    // Idle with in == 0: nothing starts
    b0 = busy_cnt;
    p0 = pulse_cnt;
    repeat (40) @(negedge clk);
    check("idle0.busy",  64'(busy_cnt - b0),  64'(0));
    check("idle0.pulse", 64'(pulse_cnt - p0), 64'(0));
    check("idle0.bcd",   64'(bus.bcd),        64'(0));

    // Directed values
    conv(1234, "d1234");
    conv(16'hFFFF, "dFFFF");
`ifdef OUT_SSEG_EN
    check("dFFFF.dig4", 64'(bus.sseg[34:28]), 64'(7'b0000010));
`endif
    conv(7, "d7");

    // Holding the same input changes nothing
    b0 = busy_cnt;
    bcd_hold = 64'(bus.bcd);
    repeat (10) @(negedge clk);
    check("hold.busy", 64'(busy_cnt - b0), 64'(0));
    check("hold.bcd",  64'(bus.bcd),       bcd_hold);

    // Input change during conversion is picked up afterwards
    p0 = pulse_cnt;
    @(negedge clk);
    bus.in = 16'd100;
    repeat (3) @(negedge clk);
    bus.in = 16'd200;
    wait_valid(k);
    check("chg.lat1", 64'(k), 64'(LAT - 3));
    check_result(100, "chg.first");
    wait_valid(k);
    check("chg.lat2", 64'(k), 64'(LAT));
    check_result(200, "chg.second");
    @(negedge clk);
    check("chg.pulse", 64'(pulse_cnt - p0), 64'(2));

    // Reset mid-conversion aborts it; 500 reconverts after release
    p0 = pulse_cnt;
    @(negedge clk);
    bus.in = 16'd500;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy",  64'(bus.busy),  64'(0));
    check("abort.bcd",   64'(bus.bcd),   64'(0));
    check("abort.valid", 64'(bus.valid), 64'(0));
    repeat (2) @(negedge clk);
    check("abort.pulse", 64'(pulse_cnt - p0), 64'(0));
    check("abort.bcd3",  64'(bus3.bcd),       64'(0));
`ifdef OUT_SSEG_EN
    check("abort.sseg",  64'(bus.sseg),       ref_sseg(0));
`endif
    rst_n = 1'b1;
    wait_valid(k);
    check("reconv.lat", 64'(k), 64'(LAT));
    check_result(500, "reconv");
    @(negedge clk);
    check("reconv.pulse", 64'(pulse_cnt - p0), 64'(1));
    last_in = 500;

    // Boundary values around digit rollovers, and back to zero
    conv(999, "d999");
    conv(1000, "d1000");
    conv(10000, "d10000");
    conv(0, "d0");

    // Randomized values against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      v = $urandom_range(0, 65535);
      if (int'(v) == last_in) v = v ^ 32'd1;
      conv(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
